// File: rtl/multi_port_rom_pkg.sv
// Shared constants for the multi-channel ROM: counter width and parameter bounds.
// Also provides the saturating increment used by the optional access counters.
package multi_port_rom_pkg;

  localparam int CNT_WIDTH    = 16;
  localparam int LATENCY_MIN  = 1;
  localparam int LATENCY_MAX  = 3;
  localparam int CHANNELS_MAX = 8;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/multi_port_rom_read_channel.sv
// One read channel: LATENCY-stage valid/data pipeline with ready/valid handshakes.
// Optional per-channel access counter when MULTI_PORT_ROM_ACCESS_COUNT_EN is defined.
module rom_read_channel
  import multi_port_rom_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] lookup_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data
`ifdef MULTI_PORT_ROM_ACCESS_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] access_count
`endif
);

  logic [LATENCY-1:0] slot_valid;
  logic [WIDTH-1:0]   slot_data [LATENCY];
  logic               advance;
  logic               accept;

  assign advance   = !slot_valid[LATENCY-1] || rsp_ready;
  // Stage 0 may refill into a bubble even while the rest of the pipe is held.
  assign req_ready = advance || !slot_valid[0];
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_valid <= '0;
    end else begin
      if (req_ready) slot_valid[0] <= accept;
      if (advance) begin
        for (int i = 1; i < LATENCY; i++) slot_valid[i] <= slot_valid[i-1];
      end
    end
  end

  // Data slots carry no reset; their valid bits qualify them.
  always_ff @(posedge clock) begin
    if (accept) slot_data[0] <= lookup_data;
    if (advance) begin
      for (int i = 1; i < LATENCY; i++) slot_data[i] <= slot_data[i-1];
    end
  end

  assign rsp_valid = slot_valid[LATENCY-1];
  assign rsp_data  = slot_data[LATENCY-1];

`ifdef MULTI_PORT_ROM_ACCESS_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       access_count <= '0;
    else if (accept) access_count <= sat_inc(access_count);
  end
`endif

endmodule

// File: rtl/multi_port_rom.sv
// Multi-channel read-only memory; each channel is an independent pipelined reader.
// Define MULTI_PORT_ROM_ACCESS_COUNT_EN to add per-channel saturating access counters.
module multi_port_rom
  import multi_port_rom_pkg::*;
#(
  parameter int    DEPTH     = 16,
  parameter int    ADDR_BITS = 4,
  parameter int    WIDTH     = 8,
  parameter int    CHANNELS  = 2,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           req_valid,
  output logic [CHANNELS-1:0]           req_ready,
  input  logic [CHANNELS*ADDR_BITS-1:0] req_addr,
  output logic [CHANNELS-1:0]           rsp_valid,
  input  logic [CHANNELS-1:0]           rsp_ready,
  output logic [CHANNELS*WIDTH-1:0]     rsp_data
`ifdef MULTI_PORT_ROM_ACCESS_COUNT_EN
  ,
  output logic [CHANNELS*CNT_WIDTH-1:0] access_count
`endif
);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("multi_port_rom: LATENCY out of range");
  end
  if (CHANNELS < 1 || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
    $error("multi_port_rom: CHANNELS out of range");
  end
  if ((1 << ADDR_BITS) < DEPTH) begin : g_bad_addr_bits
    $error("multi_port_rom: ADDR_BITS too small for DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  // Out-of-range addresses read as zero rather than aliasing.
  function automatic logic [WIDTH-1:0] rom_word(input logic [ADDR_BITS-1:0] a);
    return (int'(a) < DEPTH) ? mem[a] : '0;
  endfunction

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] lookup;

    assign lookup = rom_word(req_addr[c*ADDR_BITS +: ADDR_BITS]);

    rom_read_channel #(
      .WIDTH  (WIDTH),
      .LATENCY(LATENCY)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid[c]),
      .req_ready   (req_ready[c]),
      .lookup_data (lookup),
      .rsp_valid   (rsp_valid[c]),
      .rsp_ready   (rsp_ready[c]),
      .rsp_data    (rsp_data[c*WIDTH +: WIDTH])
`ifdef MULTI_PORT_ROM_ACCESS_COUNT_EN
      ,
      .access_count(access_count[c*CNT_WIDTH +: CNT_WIDTH])
`endif
    );
  end

endmodule

// File: tb/tb_multi_port_rom.sv
// Bench for multi_port_rom: three instances (LATENCY 1/3/2, DEPTH 16/12/16) checked against a queue-based model.
module tb_multi_port_rom;

  localparam int ND = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_valid [ND];
  logic [1:0]  req_ready [ND];
  logic [7:0]  req_addr  [ND];
  logic [1:0]  rsp_valid [ND];
  logic [1:0]  rsp_ready [ND];
  logic [15:0] rsp_data  [ND];
`ifdef MULTI_PORT_ROM_ACCESS_COUNT_EN
  logic [31:0] access_count [ND];
`endif

  always #5 clock = ~clock;

  multi_port_rom #(.DEPTH(16), .ADDR_BITS(4), .WIDTH(8), .CHANNELS(2), .LATENCY(1)) u0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0])
`ifdef MULTI_PORT_ROM_ACCESS_COUNT_EN
    , .access_count(access_count[0])
`endif
  );

  multi_port_rom #(.DEPTH(12), .ADDR_BITS(4), .WIDTH(8), .CHANNELS(2), .LATENCY(3)) u1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1])
`ifdef MULTI_PORT_ROM_ACCESS_COUNT_EN
    , .access_count(access_count[1])
`endif
  );

  multi_port_rom #(.DEPTH(16), .ADDR_BITS(4), .WIDTH(8), .CHANNELS(2), .LATENCY(2)) u2 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_addr(req_addr[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_data(rsp_data[2])
`ifdef MULTI_PORT_ROM_ACCESS_COUNT_EN
    , .access_count(access_count[2])
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [7:0] data;
    int         h;
  } ent_t;

  ent_t       q          [ND][2][$];
  bit         seen       [ND][2];
  bit         prev_stall [ND][2];
  logic [7:0] prev_data  [ND][2];
  int         last_stall [ND][2];
  int         acc_cnt    [ND][2];

  function automatic int lat_of(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  // ROM contents are loaded as mem[i] = i*3; addresses past DEPTH read zero.
  function automatic logic [7:0] rom_model(input int d, input int a);
    if (a < ((d == 1) ? 12 : 16)) return 8'(a * 3);
    return 8'h00;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < 2; c++) begin
        logic       v, r;
        logic [7:0] dat;
        ent_t       e;
        v   = rsp_valid[d][c];
        r   = rsp_ready[d][c];
        dat = rsp_data[d][c*8 +: 8];
        if (reset) begin
          q[d][c].delete();
          seen[d][c]       = 1'b0;
          prev_stall[d][c] = 1'b0;
          last_stall[d][c] = cyc;
          acc_cnt[d][c]    = 0;
          chk("reset_rsp_valid", v, 0);
          chk("reset_req_ready", req_ready[d][c], 1);
        end else begin
          if (prev_stall[d][c]) begin
            chk("stall_hold_valid", v, 1);
            chk("stall_hold_data", dat, prev_data[d][c]);
          end
          if (v) begin
            if (q[d][c].size() == 0) begin
              chk("unexpected_rsp_valid", v, 0);
            end else begin
              e = q[d][c][0];
              if (!seen[d][c]) begin
                seen[d][c] = 1'b1;
                if (last_stall[d][c] <= e.h) chk("latency", cyc - e.h, lat_of(d));
                else                         chk("latency_min", (cyc - e.h) >= lat_of(d), 1);
              end
              chk("rsp_data", dat, e.data);
              if (r) begin
                void'(q[d][c].pop_front());
                seen[d][c] = 1'b0;
              end
            end
          end
          if (!v || r) chk("req_ready_on_advance", req_ready[d][c], 1);
          prev_stall[d][c] = v && !r;
          prev_data[d][c]  = dat;
          if (v && !r) last_stall[d][c] = cyc;
          if (req_valid[d][c] && req_ready[d][c]) begin
            e.data = rom_model(d, int'(req_addr[d][c*4 +: 4]));
            e.h    = cyc;
            q[d][c].push_back(e);
            if (acc_cnt[d][c] < 65535) acc_cnt[d][c]++;
          end
          chk("occupancy", q[d][c].size() <= lat_of(d), 1);
        end
      end
    end
    cyc++;
  end

  task automatic idle_all();
    for (int d = 0; d < ND; d++) begin
      req_valid[d] = 2'b00;
      req_addr[d]  = 8'h00;
      rsp_ready[d] = 2'b11;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int  a, acc;
    bit  took;
    reset = 1'b1;
    idle_all();
    for (int i = 0; i < 16; i++) begin
      u0.mem[i] = 8'(i * 3);
      u2.mem[i] = 8'(i * 3);
    end
    for (int i = 0; i < 12; i++) u1.mem[i] = 8'(i * 3);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    step();

    // Single read, LATENCY 1, address 5 -> 15
    req_valid[0] = 2'b01;
    req_addr[0]  = 8'h05;
    @(negedge clock);
    chk("lat1_not_yet", rsp_valid[0][0], 0);
    step();
    req_valid[0] = 2'b00;
    @(negedge clock);
    chk("lat1_valid", rsp_valid[0][0], 1);
    chk("lat1_data", rsp_data[0][7:0], 8'h0F);

    // Both channels reading the same word in the same cycle
    step();
    req_valid[0] = 2'b11;
    req_addr[0]  = 8'h77;
    step();
    req_valid[0] = 2'b00;
    @(negedge clock);
    chk("same_addr_valid", rsp_valid[0], 2'b11);
    chk("same_addr_data", rsp_data[0], 16'h1515);

    // LATENCY 3, channel 1, addresses 0..15 back to back
    step();
    for (int j = 0; j < 20; j++) begin
      req_valid[1] = (j < 16) ? 2'b10 : 2'b00;
      req_addr[1]  = {4'(j), 4'h0};
      @(negedge clock);
      chk("stream_valid", rsp_valid[1][1], (j >= 3 && j < 19));
      if (j >= 3 && j < 19)
        chk("stream_data", rsp_data[1][15:8], ((j - 3) < 12) ? 8'((j - 3) * 3) : 8'h00);
      if (j == 17) chk("oob_addr14", rsp_data[1][15:8], 8'h00);
      step();
    end
    req_valid[1] = 2'b00;

    // LATENCY 2, output stalled for 5 cycles with requests pending
    step();
    rsp_ready[2] = 2'b10;
    req_valid[2] = 2'b01;
    a   = 4;
    acc = 0;
    req_addr[2] = {4'h0, 4'(a)};
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      took = req_ready[2][0];
      if (took) acc++;
      step();
      if (took) begin
        a++;
        req_addr[2][3:0] = 4'(a);
      end
    end
    @(negedge clock);
    chk("stall_req_ready_low", req_ready[2][0], 0);
    chk("stall_accepted", acc, 2);
    chk("stall_rsp_valid", rsp_valid[2][0], 1);
    chk("stall_rsp_data", rsp_data[2][7:0], 8'h0C);
    step();
    rsp_ready[2] = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      took = req_ready[2][0];
      step();
      if (took) begin
        a++;
        req_addr[2][3:0] = 4'(a);
      end
    end
    req_valid[2] = 2'b00;
    repeat (5) step();
    chk("stall_drained", q[2][0].size(), 0);

    // Reset with requests in flight
    rsp_ready[0] = 2'b10;
    req_valid[0] = 2'b01;
    req_addr[0]  = 8'h02;
    req_valid[1] = 2'b01;
    req_addr[1]  = 8'h03;
    step();
    req_valid[0] = 2'b00;
    step();
    req_valid[1] = 2'b00;
    @(negedge clock);
    chk("pre_reset_held_valid", rsp_valid[0][0], 1);
    chk("pre_reset_inflight", q[1][0].size(), 2);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_rsp_valid_u0", rsp_valid[0], 2'b00);
    chk("async_reset_rsp_valid_u1", rsp_valid[1], 2'b00);
    chk("async_reset_req_ready_u1", req_ready[1], 2'b11);
    @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    rsp_ready[0] = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("post_reset_no_stale", rsp_valid[1][0], 0);
      chk("post_reset_req_ready", req_ready[1][0], 1);
    end

    // Randomised traffic on every channel of every instance
    for (int n = 0; n < 1500; n++) begin
      step();
      for (int d = 0; d < ND; d++) begin
        for (int c = 0; c < 2; c++) begin
          req_valid[d][c]       = ($urandom_range(3) != 0);
          req_addr[d][c*4 +: 4] = 4'($urandom_range(15));
          rsp_ready[d][c]       = ($urandom_range(2) != 0);
        end
      end
    end
    step();
    idle_all();
    repeat (8) step();
    for (int d = 0; d < ND; d++)
      for (int c = 0; c < 2; c++)
        chk("random_drained", q[d][c].size(), 0);

`ifdef MULTI_PORT_ROM_ACCESS_COUNT_EN
    @(negedge clock);
    for (int d = 0; d < ND; d++)
      for (int c = 0; c < 2; c++)
        chk("access_count_model", access_count[d][c*16 +: 16], acc_cnt[d][c]);
    @(posedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    step();
    req_valid[0] = 2'b01;
    req_addr[0]  = 8'h01;
    repeat (70000) step();
    req_valid[0] = 2'b00;
    step();
    @(negedge clock);
    chk("count_saturated_ch0", access_count[0][15:0], 16'hFFFF);
    chk("count_idle_ch1", access_count[0][31:16], 16'h0000);
    chk("count_model_ch0", access_count[0][15:0], acc_cnt[0][0]);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
